// File: rtl/ula_multiciclo_pkg.sv
// Shared definitions for the multicycle ALU: ALUOp encodings, internal op codes,
// FSM state codes, the decoded-op record and the ALUOp/funct3/funct7 decoder.
// Pure declarations; no timing or flow-control behaviour of its own.
package ula_multiciclo_pkg;

  // ALUOp field driven by the main control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // lw/sw address generation
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq compare
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Single-cycle op codes; the classic ALU-control values are kept so that
  // AND/OR/ADD/SUB read the same as in the single-cycle design.
  // RV32M ops do not fit in the 4-bit space, so they share OP_MULDIV and are
  // told apart by md_op_e (which is simply funct3).
  typedef enum logic [3:0] {
    OP_AND    = 4'b0000,
    OP_OR     = 4'b0001,
    OP_ADD    = 4'b0010,
    OP_XOR    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRL    = 4'b0101,
    OP_SUB    = 4'b0110,
    OP_SRA    = 4'b0111,
    OP_SLT    = 4'b1000,
    OP_SLTU   = 4'b1001,
    OP_MULDIV = 4'b1111
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic    illegal;
    alu_op_e op;
    md_op_e  md_op;
  } dec_t;

  function automatic dec_t decode(input logic [1:0] aluop,
                                  input logic [2:0] f3,
                                  input logic [6:0] f7,
                                  input logic       md_en);
    dec_t d;
    d.illegal = 1'b0;
    d.op      = OP_ADD;
    d.md_op   = md_op_e'(f3);
    case (aluop)
      ALUOP_ADD: d.op = OP_ADD;
      ALUOP_SUB: d.op = OP_SUB;
      ALUOP_RTYPE: begin
        if (f7 == F7_BASE) begin
          case (f3)
            3'b000:  d.op = OP_ADD;
            3'b001:  d.op = OP_SLL;
            3'b010:  d.op = OP_SLT;
            3'b011:  d.op = OP_SLTU;
            3'b100:  d.op = OP_XOR;
            3'b101:  d.op = OP_SRL;
            3'b110:  d.op = OP_OR;
            default: d.op = OP_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          if (f3 == 3'b000)      d.op = OP_SUB;
          else if (f3 == 3'b101) d.op = OP_SRA;
          else                   d.illegal = 1'b1;
        end else if (f7 == F7_MULDIV && md_en) begin
          d.op = OP_MULDIV;
        end else begin
          d.illegal = 1'b1;
        end
      end
      default: begin
        // I-type: funct7 only exists as part of the immediate; it matters
        // for the shift encodings alone.
        case (f3)
          3'b000:  d.op = OP_ADD;
          3'b001: begin
            d.op = OP_SLL;
            if (f7 != F7_BASE) d.illegal = 1'b1;
          end
          3'b010:  d.op = OP_SLT;
          3'b011:  d.op = OP_SLTU;
          3'b100:  d.op = OP_XOR;
          3'b101:  d.op = f7[5] ? OP_SRA : OP_SRL;
          3'b110:  d.op = OP_OR;
          default: d.op = OP_AND;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ula_multiciclo_muldiv_iter.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on magnitudes, one bit per clk.
// Latency: loaded on start, XLEN steps; done is high during the last step, result valid with it.
// No backpressure: start is only raised by the owner while idle; reset aborts any op in flight.
//  ports: clk, reset (sync, high), start (load operands), op (funct3), a/b (operands),
//         done (final-step cycle), result (signed-corrected, valid while done).
module ula_multiciclo_muldiv_iter
  import ula_multiciclo_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic            active;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, opnd;   // mul: {hi,lo}=partial product, lo holds multiplier
  logic            is_div;         // div: hi=partial remainder, lo=dividend->quotient
  logic            neg_res;
  logic            want_hi;        // high product word, or remainder
  logic            div_zero;
  logic [XLEN-1:0] a_raw;

  // operand preparation at start
  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op)
      MD_MULH, MD_DIV, MD_REM: begin
        a_sgn = a[XLEN-1];
        b_sgn = b[XLEN-1];
      end
      MD_MULHSU: a_sgn = a[XLEN-1];
      default: ;
    endcase
    a_mag = a_sgn ? -a : a;
    b_mag = b_sgn ? -b : b;
  end

  // one iteration step
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] hi_n, lo_n;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    if (is_div) begin
      // restore when the trial subtraction borrows
      hi_n = diff[XLEN+1] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ~diff[XLEN+1]};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
  end

  // final sign correction, applied to the outcome of the last step
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   dsel;

  always_comb begin
    prod = {hi_n, lo_n};
    if (neg_res) prod = -prod;
    dsel = want_hi ? hi_n : lo_n;
    if (neg_res) dsel = -dsel;
    if (!is_div) begin
      result = want_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end else if (div_zero) begin
      result = want_hi ? a_raw : '1;
    end else begin
      result = dsel;
    end
  end

  assign done = active && (cnt == CW'(XLEN-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      active   <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      want_hi  <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
    end else if (start) begin
      active   <= 1'b1;
      cnt      <= '0;
      hi       <= '0;
      is_div   <= op[2];
      a_raw    <= a;
      div_zero <= (b == '0);
      if (op[2]) begin
        lo      <= a_mag;
        opnd    <= b_mag;
        want_hi <= op[1];  // REM/REMU
        // remainder takes the dividend's sign, quotient the xor
        neg_res <= op[1] ? a_sgn : (a_sgn ^ b_sgn);
      end else begin
        lo      <= b_mag;
        opnd    <= a_mag;
        want_hi <= (op != MD_MUL);
        neg_res <= a_sgn ^ b_sgn;
      end
    end else if (active) begin
      hi <= hi_n;
      lo <= lo_n;
      if (done) begin
        active <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Multicycle ALU: decodes ALUOp/funct3/funct7 (RV32I + optional RV32M) and executes it.
// Latency accept->out_valid: 1 clk single-cycle/illegal, XLEN+1 clk for MUL*/DIV*/REM*.
// Accepts only in IDLE (in_ready); in_valid while busy is ignored, upstream must hold.
//  ports: clk, reset (sync, high); in_valid/in_ready, ALUOp, funct3, funct7, op_a, op_b in;
//         out_valid (1-clk pulse), out_result, out_zero, illegal, busy out.
module ula_multiciclo
  import ula_multiciclo_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            illegal,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  state_e          state, state_nxt;
  dec_t            dec;
  logic            accept;
  logic            md_start;
  logic            md_done;
  logic [XLEN-1:0] md_result;
  logic [XLEN-1:0] sc_result;
  logic [SHW-1:0]  shamt;

  assign dec      = decode(ALUOp, funct3, funct7, MULDIV_EN);
  assign accept   = in_valid && (state == ST_IDLE);
  assign md_start = accept && !dec.illegal && (dec.op == OP_MULDIV);
  assign shamt    = op_b[SHW-1:0];

  // single-cycle datapath, computed straight from the presented operands
  always_comb begin
    sc_result = '0;
    if (!dec.illegal) begin
      case (dec.op)
        OP_AND:  sc_result = op_a & op_b;
        OP_OR:   sc_result = op_a | op_b;
        OP_ADD:  sc_result = op_a + op_b;
        OP_XOR:  sc_result = op_a ^ op_b;
        OP_SLL:  sc_result = op_a << shamt;
        OP_SRL:  sc_result = op_a >> shamt;
        OP_SUB:  sc_result = op_a - op_b;
        OP_SRA:  sc_result = XLEN'($signed(op_a) >>> shamt);
        OP_SLT:  sc_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
        OP_SLTU: sc_result = {{(XLEN-1){1'b0}}, op_a < op_b};
        default: sc_result = '0;
      endcase
    end
  end

  ula_multiciclo_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .op     (dec.md_op),
    .a      (op_a),
    .b      (op_b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = md_start ? ST_CALC : ST_DONE;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (md_done) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // result registers load only on the transition into DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      out_result <= '0;
      out_zero   <= 1'b1;
      illegal    <= 1'b0;
    end else if (accept && !md_start) begin
      out_result <= sc_result;
      out_zero   <= (sc_result == '0);
      illegal    <= dec.illegal;
    end else if ((state == ST_CALC) && md_done) begin
      out_result <= md_result;
      out_zero   <= (md_result == '0);
      illegal    <= 1'b0;
    end
  end

endmodule
